// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the memory request path.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } req_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_request_ctrl.sv
// Memory request controller: fetch gating, load/store request latching,
// halt drain, stall-cycle accounting and hung-memory detection.
module mem_request_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              halt,
    input  logic              dataread,
    input  logic              datawrite,
    input  logic [ADDR_W-1:0] daddr_in,
    input  logic [WORD_W-1:0] dstore_in,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic [ADDR_W-1:0] daddr,
    output logic [WORD_W-1:0] dstore,
    output logic              pending,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic              timeout
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT) + 1;

    req_state_t        state_q, state_d;
    logic              dren_q, dren_d;
    logic              dwen_q, dwen_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [WORD_W-1:0] dstore_q, dstore_d;
    logic              timeout_q, timeout_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting, stalled;

    assign waiting = (state_q == DWAIT);
    assign stalled = waiting && !dhit;

    // A data request is latched even with halt high; halt is honoured once it drains.
    always_comb begin
        state_d   = state_q;
        dren_d    = dren_q;
        dwen_d    = dwen_q;
        daddr_d   = daddr_q;
        dstore_d  = dstore_q;
        timeout_d = timeout_q;
        case (state_q)
            RUN: begin
                if (ihit && (dataread || datawrite)) begin
                    dren_d   = dataread && !datawrite;
                    dwen_d   = datawrite;
                    daddr_d  = daddr_in;
                    dstore_d = dstore_in;
                    state_d  = DWAIT;
                end else if (halt) begin
                    state_d = HALTED;
                end
            end
            DWAIT: begin
                if (dhit) begin
                    dren_d  = 1'b0;
                    dwen_d  = 1'b0;
                    state_d = halt ? HALTED : RUN;
                end else if (wait_cnt >= WAIT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                end
            end
            HALTED: begin
                dren_d = 1'b0;
                dwen_d = 1'b0;
            end
            default: begin
                state_d = RUN;
                dren_d  = 1'b0;
                dwen_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= RUN;
            dren_q    <= 1'b0;
            dwen_q    <= 1'b0;
            daddr_q   <= '0;
            dstore_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dren_q    <= dren_d;
            dwen_q    <= dwen_d;
            daddr_q   <= daddr_d;
            dstore_q  <= dstore_d;
            timeout_q <= timeout_d;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .inc_i   (stalled),
        .clear_i (1'b0),
        .count_o (stall_cycles)
    );

    sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk_i   (CLK),
        .rst_ni  (nRST),
        .inc_i   (stalled),
        .clear_i (waiting && dhit),
        .count_o (wait_cnt)
    );

    assign iREN    = (state_q == RUN) && !halt;
    assign dREN    = dren_q;
    assign dWEN    = dwen_q;
    assign daddr   = daddr_q;
    assign dstore  = dstore_q;
    assign pending = waiting;
    assign halted  = (state_q == HALTED);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mem_request_ctrl.sv
// Directed + random bench for mem_request_ctrl against a cycle-level reference model.
module tb_mem_request_ctrl;

    localparam int ADDR_W  = 32;
    localparam int WORD_W  = 32;
    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 4;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              ihit = 1'b0, dhit = 1'b0, halt = 1'b0;
    logic              dataread = 1'b0, datawrite = 1'b0;
    logic [ADDR_W-1:0] daddr_in = '0;
    logic [WORD_W-1:0] dstore_in = '0;
    logic              iREN, dREN, dWEN, pending, halted, timeout;
    logic [ADDR_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic [CNT_W-1:0]  stall_cycles;

    mem_request_ctrl #(
        .ADDR_W  (ADDR_W),
        .WORD_W  (WORD_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .dhit         (dhit),
        .halt         (halt),
        .dataread     (dataread),
        .datawrite    (datawrite),
        .daddr_in     (daddr_in),
        .dstore_in    (dstore_in),
        .iREN         (iREN),
        .dREN         (dREN),
        .dWEN         (dWEN),
        .daddr        (daddr),
        .dstore       (dstore),
        .pending      (pending),
        .halted       (halted),
        .stall_cycles (stall_cycles),
        .timeout      (timeout)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: "busy" = a data request outstanding, "stopped" = halted for good.
    bit          m_busy, m_stopped, m_rd, m_wr, m_to;
    int unsigned m_addr, m_data;
    int          m_stall, m_wait;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".iREN"},    64'(iREN),         64'(!m_busy && !m_stopped && !halt));
        chk({tag, ".dREN"},    64'(dREN),         64'(m_rd));
        chk({tag, ".dWEN"},    64'(dWEN),         64'(m_wr));
        chk({tag, ".daddr"},   64'(daddr),        64'(m_addr));
        chk({tag, ".dstore"},  64'(dstore),       64'(m_data));
        chk({tag, ".pending"}, 64'(pending),      64'(m_busy));
        chk({tag, ".halted"},  64'(halted),       64'(m_stopped));
        chk({tag, ".stall"},   64'(stall_cycles), 64'(m_stall));
        chk({tag, ".timeout"}, 64'(timeout),      64'(m_to));
    endtask

    task automatic model_reset();
        m_busy = 0; m_stopped = 0; m_rd = 0; m_wr = 0; m_to = 0;
        m_addr = 0; m_data = 0; m_stall = 0; m_wait = 0;
    endtask

    // Async reset applied between clock edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        #1 nRST = 1'b0;
        model_reset();
        #1 check_all(tag);
        nRST = 1'b1;
    endtask

    task automatic cycle(input string tag);
        bit          n_busy, n_stopped, n_rd, n_wr, n_to;
        int unsigned n_addr, n_data;
        int          n_stall, n_wait;
        n_busy = m_busy; n_stopped = m_stopped; n_rd = m_rd; n_wr = m_wr; n_to = m_to;
        n_addr = m_addr; n_data = m_data; n_stall = m_stall; n_wait = m_wait;
        if (m_stopped) begin
            n_rd = 0; n_wr = 0;
        end else if (m_busy) begin
            if (dhit) begin
                n_rd = 0; n_wr = 0; n_wait = 0; n_busy = 0; n_stopped = halt;
            end else begin
                if (m_wait >= TIMEOUT - 1) n_to = 1;
                n_wait = m_wait + 1;
                n_stall = (m_stall < STALL_MAX) ? m_stall + 1 : STALL_MAX;
            end
        end else if (ihit && (dataread || datawrite)) begin
            n_rd = dataread && !datawrite; n_wr = datawrite;
            n_addr = daddr_in; n_data = dstore_in; n_busy = 1;
        end else if (halt) begin
            n_stopped = 1;
        end
        @(posedge CLK);
        #1;
        m_busy = n_busy; m_stopped = n_stopped; m_rd = n_rd; m_wr = n_wr; m_to = n_to;
        m_addr = n_addr; m_data = n_data; m_stall = n_stall; m_wait = n_wait;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        ihit = 0; dhit = 0; halt = 0; dataread = 0; datawrite = 0;
    endtask

    initial begin
        model_reset();
        #3 check_all("reset");
        @(negedge CLK);
        nRST = 1'b1;
        cycle("run_idle");

        // Load at 0x100, dhit after three stall cycles
        ihit = 1; dataread = 1; daddr_in = 32'h100;
        cycle("load_issue");
        chk("load_dREN", 64'(dREN), 64'd1);
        chk("load_addr", 64'(daddr), 64'h100);
        idle_inputs();
        for (int i = 0; i < 3; i++) cycle("load_wait");
        dhit = 1;
        cycle("load_done");
        dhit = 0;
        chk("load_stall", 64'(stall_cycles), 64'd3);
        chk("load_iREN", 64'(iREN), 64'd1);

        // Reset in the middle of a request
        ihit = 1; dataread = 1; daddr_in = 32'h2468;
        cycle("rst_issue");
        idle_inputs();
        cycle("rst_wait");
        do_reset("rst_mid_dwait");
        chk("rst_mid_iREN", 64'(iREN), 64'd1);
        cycle("rst_after");

        // Store with both flags; ihit during DWAIT must not disturb the request
        ihit = 1; dataread = 1; datawrite = 1; dstore_in = 32'hDEADBEEF; daddr_in = 32'h40;
        cycle("store_issue");
        chk("store_dWEN", 64'(dWEN), 64'd1);
        chk("store_dREN", 64'(dREN), 64'd0);
        dataread = 0; datawrite = 0; dstore_in = 32'h12345678; daddr_in = 32'h99;
        for (int i = 0; i < 2; i++) cycle("store_ihit_ignored");
        chk("store_held", 64'(dstore), 64'hDEADBEEF);
        idle_inputs();
        dhit = 1;
        cycle("store_done");
        dhit = 0;

        // dhit in RUN is ignored
        dhit = 1;
        cycle("dhit_in_run");
        dhit = 0;

        // Timeout
        do_reset("to_reset");
        ihit = 1; dataread = 1; daddr_in = 32'h800;
        cycle("to_issue");
        idle_inputs();
        for (int i = 0; i < 3; i++) cycle("to_wait");
        chk("to_not_yet", 64'(timeout), 64'd0);
        cycle("to_wait4");
        chk("to_set", 64'(timeout), 64'd1);
        for (int i = 0; i < 2; i++) cycle("to_wait_more");
        dhit = 1;
        cycle("to_done");
        dhit = 0;
        chk("to_sticky", 64'(timeout), 64'd1);
        chk("to_stall", 64'(stall_cycles), 64'd6);

        // Halt drain
        halt = 1; ihit = 1; datawrite = 1; dstore_in = 32'hCAFE0001;
        cycle("halt_issue");
        chk("halt_dwait_iREN", 64'(iREN), 64'd0);
        ihit = 0; datawrite = 0;
        dhit = 1;
        cycle("halt_drain");
        dhit = 0;
        chk("halt_halted", 64'(halted), 64'd1);
        halt = 0;
        for (int i = 0; i < 3; i++) cycle("halt_terminal");
        chk("halt_iREN_low", 64'(iREN), 64'd0);

        // Stall counter saturation
        do_reset("sat_reset");
        ihit = 1; dataread = 1;
        cycle("sat_issue");
        idle_inputs();
        for (int i = 0; i < 10; i++) cycle("sat_wait");
        chk("sat_stall", 64'(stall_cycles), 64'd7);
        dhit = 1;
        cycle("sat_done");

        // Randomised traffic
        do_reset("rand_reset");
        for (int n = 0; n < 400; n++) begin
            ihit      = ($urandom_range(0, 2) != 0);
            dhit      = ($urandom_range(0, 3) == 0);
            halt      = ($urandom_range(0, 24) == 0);
            dataread  = $urandom_range(0, 1) == 1;
            datawrite = $urandom_range(0, 2) == 0;
            daddr_in  = $urandom;
            dstore_in = $urandom;
            if ((m_stopped && $urandom_range(0, 3) == 0) || $urandom_range(0, 80) == 0)
                do_reset("rand_rst");
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_request_ctrl.md
Name: mem_request_ctrl

Overview:
- Parametrised memory request controller between the CPU datapath and the memory/cache interface.
- Issues instruction fetches and captures a load/store request (read/write, address, store data) on instruction hit.
- Holds that request until data hit and suppresses fetch while it is outstanding.
- Handles halt drain and counts stall cycles; a wait-timeout detector flags a hung memory.

Parameters:
ADDR_W, 32, width of data address
WORD_W, 32, width of store data
CNT_W, 16, width of saturating stall-cycle counter
TIMEOUT, 64, DWAIT cycles without dhit before timeout flag sets (>=2)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch completed this cycle
dhit  in  1  data access completed this cycle
halt  in  1  datapath halt request (level)
dataread  in  1  current instruction is a load
datawrite  in  1  current instruction is a store
daddr_in  in  ADDR_W  data address from datapath
dstore_in  in  WORD_W  store data from datapath
iREN  out  1  instruction read enable
dREN  out  1  data read enable (registered)
dWEN  out  1  data write enable (registered)
daddr  out  ADDR_W  latched data address (registered)
dstore  out  WORD_W  latched store data (registered)
pending  out  1  data request outstanding (state==DWAIT)
halted  out  1  sticky: controller halted
stall_cycles  out  CNT_W  saturating count of DWAIT cycles
timeout  out  1  sticky: TIMEOUT reached in one DWAIT episode

Behaviour:
- Reset (async, nRST=0): state RUN; dREN=dWEN=0, daddr=0, dstore=0, wait counter=0, stall_cycles=0, timeout=0, halted=0. Reset mid-DWAIT abandons the request with no completion.
- States: RUN, DWAIT, HALTED. iREN = (state==RUN) & ~halt, combinational.
- RUN:
  - ihit & (dataread|datawrite) & ~halt: next cycle dREN=dataread&~datawrite, dWEN=datawrite, daddr/dstore captured; go DWAIT. Both flags set is illegal; write wins.
  - ihit with neither flag: stay RUN.
  - halt & ~(ihit & data flag): go HALTED.
  - halt & ihit & data flag: the data request is still latched and DWAIT entered; halt is taken after completion.
  - dhit in RUN is ignored.
- DWAIT:
  - dREN/dWEN/daddr/dstore held stable; ihit ignored.
  - Each cycle without dhit: wait counter +1 and stall_cycles +1 (saturates at 2^CNT_W-1).
  - When wait counter reaches TIMEOUT-1 without dhit, timeout sets at the next edge. Timeout is sticky; the request keeps waiting.
  - dhit: next cycle dREN=dWEN=0 and wait counter=0; go HALTED if halt is high that cycle, else RUN. The dhit cycle itself is not counted.
- HALTED: iREN=0, dREN=dWEN=0, halted=1. This state is terminal until reset; halt deasserting has no effect.
- Latency: request visible on dREN/dWEN 1 cycle after ihit; fetch resumes (iREN=1) the cycle after dhit.
- Widths: daddr/dstore are plain registers. Wait counter width = $clog2(TIMEOUT)+1.

Decomposition:
- Shared package cpu_types_pkg: word_t and the req_state_t enum (RUN, DWAIT, HALTED).
- One sub-module: sat_counter (parametrised width, inc, clear, saturating). Instantiated for stall_cycles and for the wait counter.
- FSM and request registers stay in mem_request_ctrl.

Test Plan:
- Reset mid-DWAIT → nRST low during DWAIT gives dREN=dWEN=0, stall_cycles=0, state RUN, iREN=1 asynchronously.
- Load: ihit+dataread, daddr_in=0x100 → next cycle dREN=1, daddr=0x100, iREN=0. dhit after 3 cycles → stall_cycles=3, dREN=0 and iREN=1 the following cycle.
- Store with both flags: ihit+dataread+datawrite, dstore_in=0xDEADBEEF → dWEN=1, dREN=0, dstore=0xDEADBEEF held until dhit.
- Timeout (TIMEOUT=4): DWAIT with no dhit for 4 cycles → timeout=1 on the 4th cycle edge. dhit at cycle 6 → timeout stays 1, stall_cycles=6.
- Halt drain: halt+ihit+datawrite → DWAIT, iREN=0. dhit → HALTED, halted=1. Halt dropped → iREN stays 0.
- Saturation (CNT_W=3): 10 DWAIT cycles → stall_cycles=7. Extra checks: ihit during DWAIT and dhit during RUN cause no change.
